// File: rtl/rf_multiport.sv
// Multi-read-port register file with a post-reset zeroing sweep.
// Latency: reads return one cycle after ren; writes land at the edge where wen is high.
// Backpressure: none; wen/ren are ignored while busy (INIT sweep) is high.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        ren,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    output logic                     busy
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_ready;
    logic              wr_ok;

    assign in_ready = (state_q == ST_READY);
    assign busy     = (state_q == ST_INIT);

    // Writes are dropped outside READY, beyond the last entry, and to the hardwired zero entry.
    assign wr_ok = in_ready && wen
                && (32'(waddr) < 32'(DEPTH))
                && !((ZERO_REG != 0) && (waddr == '0));

    // Next-state logic: sweep every entry once, then stay in READY until reset.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Control state register; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Storage array: no reset, cleared only by the INIT sweep, otherwise written in READY.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_INIT)) begin
            mem_q[init_cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rd_val;
        logic [DATA_W-1:0] rdata_q, rdata_d;
        logic              rvalid_q, rvalid_d;

        assign ra = raddr[g*AW +: AW];

        // Read value: zero for out-of-range or the zero entry, write-first bypass otherwise.
        always_comb begin
            rd_val = '0;
            if ((32'(ra) < 32'(DEPTH)) && !((ZERO_REG != 0) && (ra == '0))) begin
                if (wen && (waddr == ra)) begin
                    rd_val = wdata;
                end else begin
                    rd_val = mem_q[ra];
                end
            end
        end

        // Capture a read only in READY; otherwise hold data and drop valid.
        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = 1'b0;
            if (in_ready && ren[g]) begin
                rdata_d  = rd_val;
                rvalid_d = 1'b1;
            end
        end

        // Read output registers; reset discards any in-flight read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = rdata_q;
        assign rvalid[g]                 = rvalid_q;
    end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning entry width in bits.
REQ-002 SHALL provide parameter DEPTH, default 4, meaning number of entries (>=2; need not be a power of 2).
REQ-003 SHALL provide parameter NUM_RD, default 2, meaning number of independent read ports (>=1).
REQ-004 SHALL provide parameter ZERO_REG, default 1, meaning that when 1, entry 0 is hardwired to zero.
REQ-005 SHALL use derived constant AW = max(1, clog2(DEPTH)), used for address width.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk, the single clock, with all state updated on its rising edge; rst, the asynchronous active-high reset.
REQ-007 SHALL provide port: clk  input  1  system clock.
REQ-008 SHALL provide port: rst  input  1  asynchronous reset, active-high.
REQ-009 SHALL provide port: wen  input  1  write enable.
REQ-010 SHALL provide port: waddr  input  AW  write address.
REQ-011 SHALL provide port: wdata  input  DATA_W  write data.
REQ-012 SHALL provide port: ren  input  NUM_RD  per-port read enable.
REQ-013 SHALL provide port: raddr  input  NUM_RD*AW  per-port read address; port i occupies slice [i*AW +: AW].
REQ-014 SHALL provide port: rdata  output  NUM_RD*DATA_W  per-port read data; port i occupies slice [i*DATA_W +: DATA_W].
REQ-015 SHALL provide port: rvalid  output  NUM_RD  per-port read-data-valid, one cycle after ren.
REQ-016 SHALL provide port: busy  output  1  high while the initialisation sweep runs.

Function
REQ-017 SHALL implement a two-state FSM, INIT and READY: INIT writes zero to entry init_cnt each cycle and increments init_cnt; after the cycle clearing entry DEPTH-1 it moves to READY, where it stays until rst.
REQ-018 SHALL drive busy=1 exactly while in INIT, i.e. for DEPTH cycles after rst deasserts.
REQ-019 SHALL ignore wen and ren while in INIT: no array update from wen, and rvalid=0.
REQ-020 SHALL, in READY, write wdata to entry waddr at the clock edge where wen=1.
REQ-021 SHALL give reads a latency of 1: ren[i]=1 at edge N produces rdata slice i = entry raddr_i and rvalid[i]=1 after edge N.
REQ-022 SHALL, when ren[i]=0 at an edge, hold rdata slice i and clear rvalid[i] to 0.
REQ-023 SHALL bypass a same-cycle write to the same address (wen=1, waddr==raddr_i, ren[i]=1): rdata slice i returns wdata, i.e. write-first.
REQ-024 SHALL return identical data on all read ports that address the same entry in the same cycle.
REQ-025 SHALL, when ZERO_REG=1, discard writes to address 0 and return 0 for reads of address 0, including the bypass case.
REQ-026 SHALL ignore writes to addresses >= DEPTH and return 0 with rvalid=1 for reads of such addresses.
REQ-027 SHALL NOT let the array content change other than through INIT or a READY write.

Reset
REQ-028 SHALL, while rst=1, immediately force state=INIT, init_cnt=0, busy=1, rvalid=0 and rdata=0.
REQ-029 SHALL restart the sweep from entry 0 when rst is asserted mid-INIT or mid-READY, discarding any in-flight reads.
REQ-030 SHALL NOT rely on the asynchronous reset for array contents; array clearing SHALL be done by the INIT sweep only.

Verification (DATA_W=32, DEPTH=4, NUM_RD=2, ZERO_REG=1)
REQ-031 SHALL cover: release rst -> busy=1 for exactly 4 cycles, then 0; then reading addresses 0..3 on both ports -> all 0x00000000 with rvalid=1.
REQ-032 SHALL cover: write 0xDEADBEEF to addr 3, then ren[0]=1 with raddr0=3 on the next cycle -> one cycle later rdata0=0xDEADBEEF and rvalid[0]=1; the following cycle with ren[0]=0 -> rvalid[0]=0 and rdata0 still 0xDEADBEEF.
REQ-033 SHALL cover: in one cycle, wen=1, waddr=1, wdata=0x5, ren[1]=1, raddr1=1 -> next cycle rdata1=0x00000005; simultaneously ren[0] on addr 2 holding 0x4 -> rdata0=0x00000004.
REQ-034 SHALL cover: write 0x4 to addr 0, then read addr 0 on both ports -> both return 0x00000000; same-cycle bypass to addr 0 also returns 0.
REQ-035 SHALL cover: with addr 2 holding 0x12345678, assert rst at the second INIT cycle after a prior release -> rvalid=0 immediately; after release busy=1 for 4 full cycles; then addr 2 reads 0.
REQ-036 SHALL cover: during busy, wen=1 with waddr=2, wdata=0xA5A5A5A5, and ren=2'b11 -> rvalid stays 00; after READY, addr 2 reads 0x00000000.
